// File: rtl/cpu_seq_controller.sv
// Multi-cycle fetch/decode/execute controller: owns PC and IR, fetches over
// a req/ack memory handshake and sequences the datapath control pins.
module cpu_seq_controller #(
    parameter int AW = 9,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_ack,
    input  logic [15:0]   dp_out,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic [15:0]   ir,
    output logic [AW-1:0] pc,
    output logic [2:0]    nsel,
    output logic [3:0]    vsel,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          write,
    output logic          asel,
    output logic          bsel,
    output logic          halted,
    output logic          err
);

    typedef enum logic [4:0] {
        S_RST, S_FETCH, S_DECODE, S_W_IMM,
        S_LA, S_LB, S_EX, S_WB, S_CMPS,
        S_ADDR, S_LATCH, S_MRD, S_W_MEM,
        S_LBD, S_EXD, S_MWR, S_HALTED, S_ERR
    } state_t;

    typedef enum logic [3:0] {
        OP_MOVI, OP_MOVS, OP_ADD, OP_CMP, OP_AND,
        OP_MVN, OP_LDR, OP_STR, OP_HALT, OP_ILL
    } op_t;

    state_t        state;
    state_t        nxt;
    op_t           op;
    logic [AW-1:0] addr_q;

    always_comb begin
        case (ir[15:11])
            5'b11010: op = OP_MOVI;
            5'b11000: op = OP_MOVS;
            5'b10100: op = OP_ADD;
            5'b10101: op = OP_CMP;
            5'b10110: op = OP_AND;
            5'b10111: op = OP_MVN;
            5'b01100: op = OP_LDR;
            5'b10000: op = OP_STR;
            5'b11100: op = OP_HALT;
            default:  op = OP_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_RST;
            pc     <= RESET_PC;
            ir     <= '0;
            addr_q <= '0;
        end else begin
            state <= nxt;
            if (state == S_FETCH && mem_ack) begin
                ir <= mem_rdata;
                pc <= pc + AW'(1);
            end
            if (state == S_LATCH)
                addr_q <= dp_out[AW-1:0];
        end
    end

    assign mem_wdata = dp_out;

    always_comb begin
        nxt      = state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        nsel     = 3'b000;
        vsel     = 4'b0000;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        write    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        halted   = 1'b0;
        err      = 1'b0;
        case (state)
            S_RST: nxt = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ack) nxt = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_MOVI:         nxt = S_W_IMM;
                    OP_MOVS, OP_MVN: nxt = S_LB;
                    OP_ADD, OP_AND,
                    OP_CMP, OP_LDR,
                    OP_STR:          nxt = S_LA;
                    OP_HALT:         nxt = S_HALTED;
                    default:         nxt = S_ERR;
                endcase
            end
            S_W_IMM: begin
                nsel  = 3'b001;
                vsel  = 4'b0100;
                write = 1'b1;
                nxt   = S_FETCH;
            end
            S_LA: begin
                nsel  = 3'b001;
                loada = 1'b1;
                if (op == OP_LDR || op == OP_STR)
                    nxt = S_ADDR;
                else
                    nxt = S_LB;
            end
            S_LB: begin
                nsel  = 3'b100;
                loadb = 1'b1;
                nxt   = (op == OP_CMP) ? S_CMPS : S_EX;
            end
            S_EX: begin
                // single-operand ops pass B through with A forced to zero
                asel  = (op == OP_MOVS || op == OP_MVN);
                loadc = 1'b1;
                nxt   = S_WB;
            end
            S_WB: begin
                nsel  = 3'b010;
                vsel  = 4'b0001;
                write = 1'b1;
                nxt   = S_FETCH;
            end
            S_CMPS: begin
                loads = 1'b1;
                nxt   = S_FETCH;
            end
            S_ADDR: begin
                bsel  = 1'b1;
                loadc = 1'b1;
                nxt   = S_LATCH;
            end
            S_LATCH: nxt = (op == OP_STR) ? S_LBD : S_MRD;
            S_MRD: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) nxt = S_W_MEM;
            end
            S_W_MEM: begin
                nsel  = 3'b010;
                vsel  = 4'b1000;
                write = 1'b1;
                nxt   = S_FETCH;
            end
            S_LBD: begin
                nsel  = 3'b010;
                loadb = 1'b1;
                nxt   = S_EXD;
            end
            S_EXD: begin
                asel  = 1'b1;
                loadc = 1'b1;
                nxt   = S_MWR;
            end
            S_MWR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) nxt = S_FETCH;
            end
            S_HALTED: halted = 1'b1;
            S_ERR:    err = 1'b1;
            default:  nxt = S_RST;
        endcase
    end

endmodule

// File: tb/tb_cpu_seq_controller.sv
// Bench for cpu_seq_controller: directed table, randomized instruction
// stream against a micro-op model, and reset/wrap/halt corner sequences.
module tb_cpu_seq_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_ack;
    logic [15:0] mem_rdata, dp_out;
    logic        mem_req, mem_we;
    logic [8:0]  mem_addr, pc;
    logic [15:0] mem_wdata, ir;
    logic [2:0]  nsel;
    logic [3:0]  vsel;
    logic        loada, loadb, loadc, loads;
    logic        write, asel, bsel, halted, err;

    logic        b_reset, b_mem_ack;
    logic [15:0] b_mem_rdata, b_dp_out;
    logic        b_mem_req, b_mem_we;
    logic [3:0]  b_mem_addr, b_pc;
    logic [15:0] b_mem_wdata, b_ir;
    logic [2:0]  b_nsel;
    logic [3:0]  b_vsel;
    logic        b_loada, b_loadb, b_loadc, b_loads;
    logic        b_write, b_asel, b_bsel, b_halted, b_err;

    cpu_seq_controller dut (
        .clk(clk), .reset(reset),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dp_out(dp_out), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .ir(ir), .pc(pc),
        .nsel(nsel), .vsel(vsel),
        .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads),
        .write(write), .asel(asel), .bsel(bsel),
        .halted(halted), .err(err)
    );

    cpu_seq_controller #(.AW(4), .RESET_PC(4'hF)) dut_b (
        .clk(clk), .reset(b_reset),
        .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
        .dp_out(b_dp_out), .mem_req(b_mem_req),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .ir(b_ir), .pc(b_pc),
        .nsel(b_nsel), .vsel(b_vsel),
        .loada(b_loada), .loadb(b_loadb),
        .loadc(b_loadc), .loads(b_loads),
        .write(b_write), .asel(b_asel), .bsel(b_bsel),
        .halted(b_halted), .err(b_err)
    );

    logic [15:0] ctl;
    assign ctl = {nsel, vsel, loada, loadb, loadc, loads,
                  write, asel, bsel, halted, err};

    // control word layout: nsel, vsel, la lb lc ls wr as bs hl er
    localparam logic [15:0] C_WIMM = {3'b001, 4'b0100, 9'b000010000};
    localparam logic [15:0] C_LA   = {3'b001, 4'b0000, 9'b100000000};
    localparam logic [15:0] C_LB   = {3'b100, 4'b0000, 9'b010000000};
    localparam logic [15:0] C_EXA  = {3'b000, 4'b0000, 9'b001001000};
    localparam logic [15:0] C_EX   = {3'b000, 4'b0000, 9'b001000000};
    localparam logic [15:0] C_WB   = {3'b010, 4'b0001, 9'b000010000};
    localparam logic [15:0] C_CMPS = {3'b000, 4'b0000, 9'b000100000};
    localparam logic [15:0] C_ADDR = {3'b000, 4'b0000, 9'b001000100};
    localparam logic [15:0] C_WMEM = {3'b010, 4'b1000, 9'b000010000};
    localparam logic [15:0] C_LBD  = {3'b010, 4'b0000, 9'b010000000};
    localparam logic [15:0] C_HALT = {3'b000, 4'b0000, 9'b000000010};
    localparam logic [15:0] C_ERR  = {3'b000, 4'b0000, 9'b000000001};

    localparam int K_CTL = 0, K_FETCH = 1, K_MRD = 2;
    localparam int K_MWR = 3, K_LATCH = 4, K_STOP = 5;

    typedef struct {
        int          kind;
        logic [15:0] ctl;
    } ph_t;

    typedef struct {
        logic [15:0] ins;
        int          fw, mw;
        logic [15:0] a, d;
        int          lat, nwr;
        logic [8:0]  daddr;
        logic        dwe;
        logic [15:0] dwd;
    } vec_t;

    ph_t         plan[$];
    vec_t        tbl[9];
    logic [4:0]  keys[8];
    logic [8:0]  epc;
    logic [15:0] last_ins;
    int          nvec = 0;
    int          nmis = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit legal(input logic [4:0] k);
        foreach (keys[i]) if (keys[i] == k) return 1'b1;
        return (k == 5'b11100);
    endfunction

    // instruction -> ordered list of controller steps
    function automatic void build(input logic [15:0] ins);
        plan.delete();
        plan.push_back('{K_FETCH, 16'h0});
        plan.push_back('{K_CTL, 16'h0});
        case (ins[15:11])
            5'b11010: plan.push_back('{K_CTL, C_WIMM});
            5'b11000, 5'b10111: begin
                plan.push_back('{K_CTL, C_LB});
                plan.push_back('{K_CTL, C_EXA});
                plan.push_back('{K_CTL, C_WB});
            end
            5'b10100, 5'b10110: begin
                plan.push_back('{K_CTL, C_LA});
                plan.push_back('{K_CTL, C_LB});
                plan.push_back('{K_CTL, C_EX});
                plan.push_back('{K_CTL, C_WB});
            end
            5'b10101: begin
                plan.push_back('{K_CTL, C_LA});
                plan.push_back('{K_CTL, C_LB});
                plan.push_back('{K_CTL, C_CMPS});
            end
            5'b01100: begin
                plan.push_back('{K_CTL, C_LA});
                plan.push_back('{K_CTL, C_ADDR});
                plan.push_back('{K_LATCH, 16'h0});
                plan.push_back('{K_MRD, 16'h0});
                plan.push_back('{K_CTL, C_WMEM});
            end
            5'b10000: begin
                plan.push_back('{K_CTL, C_LA});
                plan.push_back('{K_CTL, C_ADDR});
                plan.push_back('{K_LATCH, 16'h0});
                plan.push_back('{K_CTL, C_LBD});
                plan.push_back('{K_CTL, C_EXA});
                plan.push_back('{K_MWR, 16'h0});
            end
            5'b11100: plan.push_back('{K_STOP, C_HALT});
            default:  plan.push_back('{K_STOP, C_ERR});
        endcase
    endfunction

    task automatic rst();
        reset = 1'b1;
        mem_ack = 1'($urandom);
        tick();
        reset = 1'b0;
        mem_ack = 1'b0;
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 9'h0);
        chk("rst_ctl", ctl, 16'h0);
        chk("rst_pc", pc, 9'h0);
        chk("rst_ir", ir, 16'h0);
        tick();
        epc = 9'h0;
        last_ins = 16'h0;
    endtask

    task automatic run(input logic [15:0] ins, input int fw,
                       input int mw, input logic [15:0] a,
                       input logic [15:0] d, output bit stopped);
        stopped = 1'b0;
        build(ins);
        foreach (plan[i]) begin
            case (plan[i].kind)
                K_FETCH: begin
                    for (int k = 0; k <= fw; k++) begin
                        mem_ack = (k == fw);
                        mem_rdata = (k == fw) ? ins : 16'($urandom);
                        dp_out = 16'($urandom);
                        chk("fetch_req", mem_req, 1'b1);
                        chk("fetch_we", mem_we, 1'b0);
                        chk("fetch_addr", mem_addr, epc);
                        chk("fetch_ctl", ctl, 16'h0);
                        chk("ir_hold", ir, last_ins);
                        tick();
                    end
                    epc = epc + 9'd1;
                    last_ins = ins;
                    chk("ir_load", ir, ins);
                    chk("pc_inc", pc, epc);
                end
                K_MRD, K_MWR: begin
                    for (int k = 0; k <= mw; k++) begin
                        mem_ack = (k == mw);
                        mem_rdata = 16'($urandom);
                        dp_out = (plan[i].kind == K_MWR) ? d : 16'($urandom);
                        chk("dmem_req", mem_req, 1'b1);
                        chk("dmem_we", mem_we, plan[i].kind == K_MWR);
                        chk("dmem_addr", mem_addr, a[8:0]);
                        chk("dmem_ctl", ctl, 16'h0);
                        if (plan[i].kind == K_MWR)
                            chk("dmem_wdata", mem_wdata, d);
                        tick();
                    end
                end
                K_STOP: begin
                    for (int k = 0; k < 3; k++) begin
                        mem_ack = 1'($urandom);
                        chk("stop_req", mem_req, 1'b0);
                        chk("stop_ctl", ctl, plan[i].ctl);
                        tick();
                    end
                    stopped = 1'b1;
                end
                default: begin
                    mem_ack = 1'($urandom);
                    mem_rdata = 16'($urandom);
                    dp_out = (plan[i].kind == K_LATCH) ? a : 16'($urandom);
                    chk("step_req", mem_req, 1'b0);
                    chk("step_addr", mem_addr, 9'h0);
                    chk("step_ctl", ctl, plan[i].ctl);
                    tick();
                end
            endcase
        end
    endtask

    // reactive memory: measures latency from FETCH to the next FETCH
    task automatic react(input vec_t v, output int lat, output int nwr,
                         output logic [8:0] daddr, output logic dwe,
                         output logic [15:0] dwd);
        int c = 0;
        int w = 0;
        bit fetched = 1'b0;
        bit nf;
        lat = -1;
        nwr = 0;
        daddr = 9'h0;
        dwe = 1'b0;
        dwd = 16'h0;
        while (c < 40) begin
            if (fetched && mem_req && !mem_we && mem_addr == pc) begin
                lat = c;
                break;
            end
            if (!fetched && c > 0) chk("tbl_ir_hold", ir, last_ins);
            dp_out = (mem_req && mem_we) ? v.d : v.a;
            mem_rdata = fetched ? 16'hBEEF : v.ins;
            #1;
            if (fetched && mem_req) begin
                daddr = mem_addr;
                dwe = mem_we;
                if (mem_we) dwd = mem_wdata;
            end
            if (write) nwr++;
            nf = 1'b0;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (w == (fetched ? v.mw : v.fw)) begin
                    mem_ack = 1'b1;
                    w = 0;
                    nf = !fetched;
                end else begin
                    w++;
                end
            end
            tick();
            c++;
            if (nf) fetched = 1'b1;
        end
        last_ins = v.ins;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, nwr;
        logic [8:0] daddr;
        logic dwe;
        logic [15:0] dwd, ins;
        bit stopped;

        keys = '{5'b11010, 5'b11000, 5'b10100, 5'b10101,
                 5'b10110, 5'b10111, 5'b01100, 5'b10000};
        tbl[0] = '{16'hD107, 0, 0, 16'h0, 16'h0, 3, 1, 9'h0, 1'b0, 16'h0};
        tbl[1] = '{16'hA0A2, 3, 0, 16'h0, 16'h0, 9, 1, 9'h0, 1'b0, 16'h0};
        tbl[2] = '{16'h6045, 0, 0, 16'h0123, 16'h0, 7, 1,
                   9'h123, 1'b0, 16'h0};
        tbl[3] = '{16'h8041, 0, 2, 16'h0010, 16'h5A5A, 10, 0,
                   9'h010, 1'b1, 16'h5A5A};
        tbl[4] = '{16'hA822, 0, 0, 16'h0, 16'h0, 5, 0, 9'h0, 1'b0, 16'h0};
        tbl[5] = '{16'hC020, 1, 0, 16'h0, 16'h0, 6, 1, 9'h0, 1'b0, 16'h0};
        tbl[6] = '{16'hB043, 2, 0, 16'h0, 16'h0, 8, 1, 9'h0, 1'b0, 16'h0};
        tbl[7] = '{16'hB8E1, 0, 0, 16'h0, 16'h0, 5, 1, 9'h0, 1'b0, 16'h0};
        tbl[8] = '{16'h6045, 1, 3, 16'h01FF, 16'h0, 11, 1,
                   9'h1FF, 1'b0, 16'h0};

        reset = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = 16'h0;
        dp_out = 16'h0;
        b_reset = 1'b1;
        b_mem_ack = 1'b0;
        b_mem_rdata = 16'h0;
        b_dp_out = 16'h0;
        tick();
        tick();
        b_reset = 1'b0;
        rst();

        foreach (tbl[i]) begin
            react(tbl[i], lat, nwr, daddr, dwe, dwd);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_ir", i), ir, tbl[i].ins);
            chk($sformatf("tbl%0d_nwr", i), nwr, tbl[i].nwr);
            chk($sformatf("tbl%0d_daddr", i), daddr, tbl[i].daddr);
            chk($sformatf("tbl%0d_dwe", i), dwe, tbl[i].dwe);
            chk($sformatf("tbl%0d_dwd", i), dwd, tbl[i].dwd);
        end
        epc = 9'd9;

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 19))
                0: ins = {5'b11100, 11'($urandom)};
                1: begin
                    do ins = 16'($urandom); while (legal(ins[15:11]));
                end
                default: ins = {keys[$urandom_range(0, 7)], 11'($urandom)};
            endcase
            run(ins, $urandom_range(0, 3), $urandom_range(0, 3),
                16'($urandom), 16'($urandom), stopped);
            if (stopped) rst();
        end

        rst();
        mem_ack = 1'b1;
        mem_rdata = 16'h6045;
        tick();
        mem_ack = 1'b0;
        tick();
        tick();
        tick();
        dp_out = 16'h0123;
        tick();
        chk("mrd_req", mem_req, 1'b1);
        chk("mrd_addr", mem_addr, 9'h123);
        chk("mrd_we", mem_we, 1'b0);
        reset = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'hFFFF;
        tick();
        reset = 1'b0;
        mem_ack = 1'b0;
        chk("mrdrst_req", mem_req, 1'b0);
        chk("mrdrst_pc", pc, 9'h0);
        chk("mrdrst_ir", ir, 16'h0);
        chk("mrdrst_flags", {halted, err}, 2'b00);
        tick();
        chk("restart_req", mem_req, 1'b1);
        chk("restart_addr", mem_addr, 9'h0);

        b_reset = 1'b1;
        tick();
        b_reset = 1'b0;
        chk("b_rst_pc", b_pc, 4'hF);
        chk("b_rst_req", b_mem_req, 1'b0);
        tick();
        chk("b_fetch_addr", b_mem_addr, 4'hF);
        chk("b_fetch_req", b_mem_req, 1'b1);
        b_mem_ack = 1'b1;
        b_mem_rdata = 16'hD107;
        tick();
        b_mem_ack = 1'b0;
        chk("b_pc_wrap", b_pc, 4'h0);
        chk("b_ir", b_ir, 16'hD107);
        tick();
        chk("b_wimm", {b_nsel, b_vsel, b_write}, {3'b001, 4'b0100, 1'b1});
        tick();
        chk("b_fetch0_addr", b_mem_addr, 4'h0);
        chk("b_fetch0_req", b_mem_req, 1'b1);
        b_mem_ack = 1'b1;
        b_mem_rdata = 16'hE000;
        tick();
        b_mem_ack = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            b_mem_ack = 1'($urandom);
            chk("b_halted", b_halted, 1'b1);
            chk("b_halt_req", b_mem_req, 1'b0);
            tick();
        end
        b_reset = 1'b1;
        b_mem_ack = 1'b0;
        tick();
        b_reset = 1'b0;
        tick();
        b_mem_ack = 1'b1;
        b_mem_rdata = 16'h0000;
        tick();
        b_mem_ack = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("b_err", {b_err, b_halted, b_mem_req}, 3'b100);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
